// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: ALU op codes and FSM state encoding.
package alu_pkg;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_NOR = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU: add, sub, and, nor. All results wrap modulo 2^WIDTH.
module alu_arbiter_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       alu_control,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  // Select the operation; carry and overflow are simply dropped.
  always_comb begin
    result = '0;
    case (alu_control)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_NOR: result = ~(a | b);
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between NUM_REQ requesters.
// Flow: IDLE (arbitrate + accept) -> EXEC (compute) -> RESP (hold until taken).
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = 32,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ*2-1:0]     req_op,
  output logic [NUM_REQ-1:0]       rsp_valid,
  input  logic [NUM_REQ-1:0]       rsp_ready,
  output logic [WIDTH-1:0]         rsp_result,
  output logic                     rsp_zero,
  output logic                     busy
);

  // Pick the first valid index starting at ptr, wrapping by explicit compare so
  // non-power-of-two NUM_REQ works. Scanning far-to-near lets the nearest win.
  // Returns {found, index}.
  function automatic logic [PTR_W:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                             input logic [PTR_W-1:0]   ptr);
    logic [PTR_W:0]   pick;
    logic [PTR_W-1:0] idx_p;
    int               idx;
    pick = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idx_p = PTR_W'(idx);
      if (valid[idx_p]) pick = {1'b1, idx_p};
    end
    return pick;
  endfunction

  logic [WIDTH-1:0] w_a_arr  [NUM_REQ];
  logic [WIDTH-1:0] w_b_arr  [NUM_REQ];
  logic [1:0]       w_op_arr [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_a_arr[gi]  = req_a[gi*WIDTH +: WIDTH];
      assign w_b_arr[gi]  = req_b[gi*WIDTH +: WIDTH];
      assign w_op_arr[gi] = req_op[gi*2 +: 2];
    end
  endgenerate

  state_t           r_state;
  state_t           w_state_next;
  logic [PTR_W-1:0] r_rr_ptr;
  logic [PTR_W-1:0] r_grant;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;

  logic [PTR_W:0]     w_pick;
  logic               w_found;
  logic [PTR_W-1:0]   w_win;
  logic [PTR_W-1:0]   w_next_ptr;
  logic [NUM_REQ-1:0] w_req_ready;
  logic [NUM_REQ-1:0] w_rsp_valid;
  logic               w_accept;
  logic               w_release;
  logic [WIDTH-1:0]   w_alu_result;
  logic               w_alu_zero;

  assign w_pick  = rr_pick(req_valid, r_rr_ptr);
  assign w_found = w_pick[PTR_W];
  assign w_win   = w_pick[PTR_W-1:0];

  assign w_next_ptr = (r_grant == PTR_W'(NUM_REQ - 1)) ? '0 : r_grant + 1'b1;

  alu_arbiter_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .a           (r_a),
    .b           (r_b),
    .alu_control (r_op),
    .result      (w_alu_result),
    .zero        (w_alu_zero)
  );

  // Next-state and handshake decode; everything defaults to idle/zero.
  always_comb begin
    w_state_next = r_state;
    w_req_ready  = '0;
    w_rsp_valid  = '0;
    w_accept     = 1'b0;
    w_release    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_req_ready[w_win] = 1'b1;
          w_accept           = 1'b1;
          w_state_next       = EXEC;
        end
      end
      EXEC: w_state_next = RESP;
      RESP: begin
        w_rsp_valid[r_grant] = 1'b1;
        if (rsp_ready[r_grant]) begin
          w_release    = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Latch operands on accept, capture the ALU output in EXEC, advance the pointer on release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
      r_grant  <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_grant <= w_win;
        r_a     <= w_a_arr[w_win];
        r_b     <= w_b_arr[w_win];
        r_op    <= w_op_arr[w_win];
      end
      if (r_state == EXEC) begin
        r_result <= w_alu_result;
        r_zero   <= (w_alu_result == '0);
      end
      if (w_release) r_rr_ptr <= w_next_ptr;
    end
  end

  // The ALU's own zero flag must always agree with the result we register from.
  always_comb begin
    assert (w_alu_zero == (w_alu_result == '0));
  end

  // Accept is never offered while reset is held.
  assign req_ready  = w_req_ready & {NUM_REQ{rst_n}};
  assign rsp_valid  = w_rsp_valid;
  assign rsp_result = r_result;
  assign rsp_zero   = r_zero;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a 2-requester/32-bit instance for reset, ops,
// fairness and backpressure, and a 3-requester/8-bit instance for pointer wrap.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // 2-requester instance
  logic [1:0]  req_valid2, req_ready2, rsp_valid2, rsp_ready2;
  logic [63:0] req_a2, req_b2;
  logic [3:0]  req_op2;
  logic [31:0] rsp_result2;
  logic        rsp_zero2, busy2;

  // 3-requester instance
  logic [2:0]  req_valid3, req_ready3, rsp_valid3, rsp_ready3;
  logic [23:0] req_a3, req_b3;
  logic [5:0]  req_op3;
  logic [7:0]  rsp_result3;
  logic        rsp_zero3, busy3;

  alu_arbiter #(.NUM_REQ(2), .WIDTH(32)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid2), .req_ready(req_ready2),
    .req_a(req_a2), .req_b(req_b2), .req_op(req_op2),
    .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2),
    .rsp_result(rsp_result2), .rsp_zero(rsp_zero2), .busy(busy2)
  );

  alu_arbiter #(.NUM_REQ(3), .WIDTH(8)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid3), .req_ready(req_ready3),
    .req_a(req_a3), .req_b(req_b3), .req_op(req_op3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
    .rsp_result(rsp_result3), .rsp_zero(rsp_zero3), .busy(busy3)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One op on the 2-requester instance, rsp_ready held high, starting in IDLE.
  task automatic op2(input int r, input logic [31:0] a, input logic [31:0] b,
                     input logic [1:0] op, input logic [31:0] exp_res, input logic exp_zero);
    int t0;
    rsp_ready2      = 2'b11;
    req_valid2      = 2'b00;
    req_valid2[r]   = 1'b1;
    req_a2[r*32 +: 32] = a;
    req_b2[r*32 +: 32] = b;
    req_op2[r*2 +: 2]  = op;
    #1;
    check("op2_req_ready", 64'(req_ready2), 64'(1) << r);
    tick();  // handshake edge
    t0 = cyc;
    req_valid2 = 2'b00;
    req_a2     = {2{32'hDEAD_BEEF}};  // operands are latched, so junk now is harmless
    req_b2     = {2{32'h1234_5678}};
    req_op2    = 4'b1111;
    #1;
    check("op2_exec_busy", 64'(busy2), 64'(1));
    check("op2_exec_rsp_valid", 64'(rsp_valid2), 64'(0));
    tick();
    check("op2_rsp_latency", 64'(cyc - t0), 64'(1));
    check("op2_rsp_valid", 64'(rsp_valid2), 64'(1) << r);
    check("op2_rsp_result", 64'(rsp_result2), 64'(exp_res));
    check("op2_rsp_zero", 64'(rsp_zero2), 64'(exp_zero));
    $display("txn dut2 req=%0d op=%0d a=%h b=%h result=%h zero=%0d",
             r, op, a, b, rsp_result2, rsp_zero2);
    tick();
    check("op2_back_idle", 64'(busy2), 64'(0));
    check("op2_rsp_cleared", 64'(rsp_valid2), 64'(0));
  endtask

  int last_cyc;
  int exp_g;
  logic [7:0] exp3 [3];

  initial begin
    rst_n      = 1'b0;
    req_valid2 = '0; req_a2 = '0; req_b2 = '0; req_op2 = '0; rsp_ready2 = '0;
    req_valid3 = '0; req_a3 = '0; req_b3 = '0; req_op3 = '0; rsp_ready3 = '0;

    // Reset state, with a request pending: nothing may be offered.
    req_valid2 = 2'b01;
    tick(); tick();
    check("rst_req_ready", 64'(req_ready2), 64'(0));
    check("rst_rsp_valid", 64'(rsp_valid2), 64'(0));
    check("rst_rsp_result", 64'(rsp_result2), 64'(0));
    check("rst_rsp_zero", 64'(rsp_zero2), 64'(0));
    check("rst_busy", 64'(busy2), 64'(0));
    check("rst_busy3", 64'(busy3), 64'(0));
    req_valid2 = 2'b00;
    rst_n = 1'b1;

    // Leave a nonzero result behind, then abort an op mid-EXEC.
    op2(0, 32'h0000_00FF, 32'd1, ALU_ADD, 32'h0000_0100, 1'b0);
    req_valid2 = 2'b01; req_a2[31:0] = 32'd7; req_b2[31:0] = 32'd1; req_op2[1:0] = ALU_ADD;
    #1;
    check("abort_req_ready", 64'(req_ready2), 64'(1));
    tick();
    req_valid2 = 2'b00;
    #1;
    check("abort_in_exec", 64'(busy2), 64'(1));
    rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy2), 64'(0));
    check("abort_rsp_valid", 64'(rsp_valid2), 64'(0));
    check("abort_rsp_result", 64'(rsp_result2), 64'(0));
    check("abort_rsp_zero", 64'(rsp_zero2), 64'(0));
    tick(); tick();
    check("abort_no_rsp", 64'(rsp_valid2), 64'(0));
    rst_n = 1'b1;

    // First grant in the first IDLE cycle after release.
    op2(0, 32'd1, 32'd3, ALU_ADD, 32'd4, 1'b0);

    // Ops sweep on requester 1.
    op2(1, 32'd1, 32'd3, ALU_SUB, 32'hFFFF_FFFE, 1'b0);
    op2(1, 32'd1, 32'd3, ALU_AND, 32'h0000_0001, 1'b0);
    op2(1, 32'd1, 32'd3, ALU_NOR, 32'hFFFF_FFFC, 1'b0);
    op2(1, 32'd5, 32'd5, ALU_SUB, 32'h0000_0000, 1'b1);

    // Fairness: both valid, pointer is 0 after requester 1 was served.
    req_valid2 = 2'b11;
    req_a2     = {32'd10, 32'd10};
    req_b2     = {32'd1, 32'd1};
    req_op2    = {ALU_SUB, ALU_ADD};
    rsp_ready2 = 2'b11;
    last_cyc   = 0;
    #1;
    for (int k = 0; k < 4; k++) begin
      exp_g = k % 2;
      check("fair_req_ready", 64'(req_ready2), 64'(1) << exp_g);
      tick(); tick();
      check("fair_rsp_valid", 64'(rsp_valid2), 64'(1) << exp_g);
      check("fair_rsp_result", 64'(rsp_result2), (exp_g == 1) ? 64'd9 : 64'd11);
      if (k > 0) check("fair_spacing", 64'(cyc - last_cyc), 64'd3);
      last_cyc = cyc;
      $display("txn dut2 fair grant=%0d result=%0d cyc=%0d", exp_g, rsp_result2, cyc);
      tick();
    end

    // Backpressure on requester 0, then a stray rsp_ready on requester 1.
    rsp_ready2 = 2'b00;
    #1;
    check("bp_req_ready", 64'(req_ready2), 64'd1);
    tick(); tick();
    check("bp_rsp_valid", 64'(rsp_valid2), 64'd1);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_hold_valid", 64'(rsp_valid2), 64'd1);
      check("bp_hold_result", 64'(rsp_result2), 64'd11);
      check("bp_req_ready_low", 64'(req_ready2), 64'd0);
    end
    rsp_ready2 = 2'b10;
    tick(); tick();
    check("stray_rsp_valid", 64'(rsp_valid2), 64'd1);
    check("stray_busy", 64'(busy2), 64'd1);
    rsp_ready2 = 2'b01;
    tick();
    check("bp_release_valid", 64'(rsp_valid2), 64'd0);
    check("bp_release_next", 64'(req_ready2), 64'd2);
    $display("txn dut2 backpressure released, next grant ready=%b", req_ready2);
    req_valid2 = 2'b00;

    // Wrap on the 3-requester instance.
    exp3[0] = 8'h04;  // 1 + 3
    exp3[1] = 8'hFF;  // 2 - 3
    exp3[2] = 8'hFC;  // ~(3 | 3)
    rsp_ready3 = 3'b111;
    req_a3     = {8'd3, 8'd2, 8'd1};
    req_b3     = {8'd3, 8'd3, 8'd3};
    req_op3    = {ALU_NOR, ALU_SUB, ALU_ADD};
    req_valid3 = 3'b100;
    #1;
    check("wrap_req_ready2", 64'(req_ready3), 64'd4);
    tick(); tick();
    check("wrap_rsp_valid2", 64'(rsp_valid3), 64'd4);
    check("wrap_rsp_result2", 64'(rsp_result3), 64'(exp3[2]));
    req_valid3 = 3'b111;
    tick();
    for (int k = 0; k < 3; k++) begin
      check("wrap_req_ready", 64'(req_ready3), 64'(1) << k);
      tick(); tick();
      check("wrap_rsp_valid", 64'(rsp_valid3), 64'(1) << k);
      check("wrap_rsp_result", 64'(rsp_result3), 64'(exp3[k]));
      $display("txn dut3 grant=%0d result=%h", k, rsp_result3);
      tick();
    end
    req_valid3 = 3'b000;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
